relu_vsq_buf: RTL and testbench

RELU_VSQ_BUF -- requirements
Module: relu_vsq_buf

---
 rtl/relu_vsq_buf.sv | 83 ++++++++
 tb/tb_relu_vsq_buf.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_vsq_buf.sv
// Row buffer between the ReLU stage and the block quantizer: applies per-lane ReLU,
// stores a DEPTH-row block, then holds it stable for one START and DEPTH DRAIN cycles.
module relu_vsq_buf #(
  parameter int LANES = 16,
  parameter int DW    = 40,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [LANES*DW-1:0] i_data,
  output logic [LANES*DW-1:0] o_relu_data,
  output logic                o_start,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [LANES*DW-1:0] o_rd_data,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       drain_cnt;
  logic                accept;
  logic [LANES*DW-1:0] relu_row;
  logic [LANES*DW-1:0] mem [DEPTH];

  // Negative lanes (MSB set) clamp to zero; non-negative lanes pass bit-exact.
  function automatic logic [LANES*DW-1:0] relu(input logic [LANES*DW-1:0] d);
    logic [LANES*DW-1:0] r;
    r = d;
    for (int k = 0; k < LANES; k++) begin
      if (d[k*DW + DW-1]) r[k*DW +: DW] = '0;
    end
    return r;
  endfunction

  assign o_ready     = (state_q == ST_FILL);
  assign o_start     = (state_q == ST_START);
  assign o_busy      = (state_q != ST_FILL);
  assign accept      = i_valid && o_ready;
  assign relu_row    = relu(i_data);
  // Idle cycles present zero so the downstream running max never sees stale data.
  assign o_relu_data = accept ? relu_row : '0;
  assign o_rd_data   = mem[i_rd_addr];

  // NOTE: next-state logic gets a default first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (accept && (wr_ptr == AW'(DEPTH-1))) state_d = ST_START;
      ST_START: state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == AW'(DEPTH-1)) state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_FILL;
      wr_ptr    <= '0;
      drain_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (state_q == ST_START)      drain_cnt <= '0;
      else if (state_q == ST_DRAIN) drain_cnt <= drain_cnt + AW'(1);
    end
  end

  // NOTE: the storage array has no reset; only the pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_ptr] <= relu_row;
  end

endmodule

// File: tb/tb_relu_vsq_buf.sv
// Directed bench for relu_vsq_buf: fill/start/drain timing, ReLU values, stall and reset behaviour.
module tb_relu_vsq_buf;
  localparam int LANES = 16;
  localparam int DW    = 40;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int W     = LANES*DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          ready;
  logic [W-1:0]  data;
  logic [W-1:0]  relu_data;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  relu_vsq_buf #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_data(data), .o_relu_data(relu_data), .o_start(start),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy)
  );

  function automatic logic [W-1:0] make_row(input int base);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'(base + k);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, then let inputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] special_in, special_exp;
  int ready_bad, early_start, rd_bad, relu_bad, nready0, start_cnt;

  initial begin
    // Special row: lane0 most-negative, lane1 = -1, lane2 = +1.0, others max positive.
    for (int k = 0; k < LANES; k++) begin
      special_in[k*DW +: DW]  = 40'h7F_FFFF_FFFF;
      special_exp[k*DW +: DW] = 40'h7F_FFFF_FFFF;
    end
    special_in[0*DW +: DW]  = 40'h80_0000_0000;
    special_in[1*DW +: DW]  = 40'hFF_FFFF_FFFF;
    special_in[2*DW +: DW]  = 40'h00_0000_0400;
    special_exp[0*DW +: DW] = '0;
    special_exp[1*DW +: DW] = '0;
    special_exp[2*DW +: DW] = 40'h00_0000_0400;

    rst_n = 1'b0; valid = 1'b0; data = make_row(32'h5555); rd_addr = '0;
    #2;
    check("rst_ready", W'(ready), W'(1));
    check("rst_start", W'(start), W'(0));
    check("rst_busy",  W'(busy),  W'(0));
    check("rst_relu_idle", relu_data, '0);
    tick();
    rst_n = 1'b1;

    // Block 1: 64 back-to-back rows, lane k = row*16+k.
    ready_bad = 0; early_start = 0;
    for (int r = 0; r < DEPTH; r++) begin
      valid = 1'b1; data = make_row(r*16);
      #1;
      if (r == 0) check("b1_relu_row0", relu_data, make_row(0));
      if (!ready) ready_bad++;
      if (start)  early_start++;
      tick();
    end
    check("b1_ready_during_fill", W'(ready_bad), W'(0));
    check("b1_no_early_start", W'(early_start), W'(0));
    // START cycle; keep valid high with the special row for the whole START/DRAIN.
    data = special_in;
    #1;
    check("b1_start_pulse", W'(start), W'(1));
    check("b1_busy_start", W'(busy), W'(1));
    check("b1_relu_stalled", relu_data, '0);
    nready0 = ready ? 0 : 1; start_cnt = 1; rd_bad = 0; relu_bad = 0;
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      rd_addr = AW'(c-1);
      #1;
      if (!ready) nready0++;
      if (start)  start_cnt++;
      if (relu_data !== '0) relu_bad++;
      if (rd_data !== make_row((c-1)*16)) rd_bad++;
    end
    check("b1_drain_read_sweep", W'(rd_bad), W'(0));
    check("b1_relu_zero_in_drain", W'(relu_bad), W'(0));
    check("b1_single_start", W'(start_cnt), W'(1));
    tick();
    check("b1_not_ready_cycles", W'(nready0), W'(65));
    check("b1_ready_after_drain", W'(ready), W'(1));
    check("b1_busy_after_drain", W'(busy), W'(0));
    check("b2_relu_special", relu_data, special_exp);
    tick();
    valid = 1'b0; rd_addr = '0;
    #1;
    check("b2_special_at_addr0", rd_data, special_exp);

    // Block 2: remaining 63 rows with i_valid alternating 0,1.
    ready_bad = 0; early_start = 0; relu_bad = 0;
    for (int r = 1; r < DEPTH; r++) begin
      if (r > 1) begin
        valid = 1'b0; data = make_row(32'hDEAD0 + r);
        #1;
        if (relu_data !== '0) relu_bad++;
        if (start) early_start++;
        tick();
      end
      valid = 1'b1; data = make_row(32'h1000 + r*16);
      #1;
      if (r == 1) check("b2_relu_row1", relu_data, make_row(32'h1000 + 16));
      if (!ready) ready_bad++;
      if (start)  early_start++;
      tick();
    end
    valid = 1'b0;
    #1;
    check("b2_relu_zero_idle", W'(relu_bad), W'(0));
    check("b2_ready_during_fill", W'(ready_bad), W'(0));
    check("b2_no_early_start", W'(early_start), W'(0));
    check("b2_start_pulse", W'(start), W'(1));
    rd_bad = 0;
    for (int c = 0; c < DEPTH; c++) begin
      tick();
      rd_addr = AW'(c);
      #1;
      if (rd_data !== ((c == 0) ? special_exp : make_row(32'h1000 + c*16))) rd_bad++;
    end
    check("b2_drain_read_sweep", W'(rd_bad), W'(0));
    tick();
    check("b2_ready_after_drain", W'(ready), W'(1));

    // Block 3: 30 rows, reset mid-fill, then 64 fresh rows.
    for (int r = 0; r < 30; r++) begin
      valid = 1'b1; data = make_row(32'h3000 + r*16);
      tick();
    end
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("b3_rst_ready", W'(ready), W'(1));
    check("b3_rst_busy", W'(busy), W'(0));
    tick();
    rst_n = 1'b1;
    early_start = 0;
    for (int r = 0; r < DEPTH; r++) begin
      valid = 1'b1; data = make_row(32'h2000 + r*16);
      #1;
      if (start) early_start++;
      tick();
    end
    valid = 1'b0; rd_addr = '0;
    #1;
    check("b3_no_early_start", W'(early_start), W'(0));
    check("b3_start_pulse", W'(start), W'(1));
    check("b3_fresh_row0_addr0", rd_data, make_row(32'h2000));
    rd_addr = AW'(29);
    #1;
    check("b3_fresh_row29", rd_data, make_row(32'h2000 + 29*16));

    // Reset mid-DRAIN aborts the block; the next row goes to address 0.
    tick(); tick(); tick();
    check("b4_busy_in_drain", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("b4_rst_drain_busy", W'(busy), W'(0));
    check("b4_rst_drain_ready", W'(ready), W'(1));
    tick();
    rst_n = 1'b1;
    valid = 1'b1; data = make_row(32'h4000);
    tick();
    valid = 1'b0; rd_addr = '0;
    #1;
    check("b4_row_at_addr0", rd_data, make_row(32'h4000));
    check("b4_no_start", W'(start), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hang if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
